// File: rtl/mem_fill_arbiter.sv
// -----------------------------------------------------------------------------
// mem_fill_arbiter
//
// Shares one single-port main memory between three requesters:
//   - I-cache miss fill     (i_miss / i_miss_addr)
//   - D-cache miss fill     (d_miss / d_miss_addr)
//   - D-side write-through  (d_wr_req / d_wr_addr / d_wr_data)
//
// A fill issues WORDS back-to-back block reads and counts the returned words.
// Each returned word is forwarded to the winning cache's data array. The tag
// write is raised together with the last data write. The memory latency is not
// assumed anywhere: the fill ends only when WORDS valid words have arrived.
// A write-through is a single-cycle memory write.
//
// Parameters:
//   WORDS    16-bit words per cache block (power of 2)
//   OFF_BITS byte-offset bits per block, log2(2*WORDS)
//   CNT_W    counter width, at least log2(WORDS)+1
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          synchronous reset, active HIGH despite the name
//   i_miss         I-cache miss request, held until i_tag_we
//   i_miss_addr    I-side miss byte address
//   d_miss         D-cache miss request, held until d_tag_we
//   d_miss_addr    D-side miss byte address
//   d_wr_req       write-through request, held until wr_done
//   d_wr_addr      write-through byte address
//   d_wr_data      write-through data
//   mem_rdata      memory read data
//   mem_data_valid memory read data valid
//   mem_addr       memory address
//   mem_wdata      memory write data
//   mem_en         memory enable
//   mem_wr         memory write strobe
//   fill_addr      cache-side address of the word being filled (0 when idle)
//   fill_data      word being filled, mem_rdata passed through (0 when idle)
//   i_fill_we      I data-array write enable
//   i_tag_we       I tag-array write enable
//   d_fill_we      D data-array write enable
//   d_tag_we       D tag-array write enable
//   wr_done        one-cycle pulse: the write-through is committed this cycle
//   busy           high whenever the arbiter is not idle
//
// Build option:
//   ARB_RR_EN  when defined, simultaneous I and D misses alternate: the side
//              opposite to the most recently completed fill wins. Without it
//              D always beats I. The write-through always has top priority.
// -----------------------------------------------------------------------------
module mem_fill_arbiter #(
  parameter int unsigned WORDS    = 8,
  parameter int unsigned OFF_BITS = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_miss,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss,
  input  logic [15:0] d_miss_addr,
  input  logic        d_wr_req,
  input  logic [15:0] d_wr_addr,
  input  logic [15:0] d_wr_data,
  input  logic [15:0] mem_rdata,
  input  logic        mem_data_valid,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] fill_addr,
  output logic [15:0] fill_data,
  output logic        i_fill_we,
  output logic        i_tag_we,
  output logic        d_fill_we,
  output logic        d_tag_we,
  output logic        wr_done,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    FILL_I = 2'd2,
    FILL_D = 2'd3
  } state_t;

  // Byte-offset bits of a block; cleared to form the block base address.
  localparam logic [15:0]      OFF_MASK = 16'((32'd1 << OFF_BITS) - 32'd1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] issue_nxt;
  logic [CNT_W-1:0] recv_cnt;
  logic [CNT_W-1:0] recv_nxt;
  logic [15:0]      blk_addr;
  logic [15:0]      blk_nxt;
  logic             grant_d;
  logic             fill_is_d;

`ifdef ARB_RR_EN
  // Side of the most recently completed fill: 0 = I, 1 = D.
  logic             last_fill;
  logic             last_fill_nxt;
`endif

  // D-versus-I decision when no write-through is pending.
  always_comb begin
`ifdef ARB_RR_EN
    // On a tie the side that did not fill last time wins.
    grant_d = d_miss && !(i_miss && last_fill);
`else
    grant_d = d_miss;
`endif
  end

  assign fill_is_d = (state == FILL_D);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    issue_nxt = issue_cnt;
    recv_nxt  = recv_cnt;
    blk_nxt   = blk_addr;
`ifdef ARB_RR_EN
    last_fill_nxt = last_fill;
`endif

    mem_addr  = '0;
    mem_wdata = '0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    fill_addr = '0;
    fill_data = '0;
    i_fill_we = 1'b0;
    i_tag_we  = 1'b0;
    d_fill_we = 1'b0;
    d_tag_we  = 1'b0;
    wr_done   = 1'b0;
    busy      = (state != IDLE);

    unique case (state)
      IDLE: begin
        // Grant is only registered here; the memory sees nothing until the
        // next cycle. Returning words seen in IDLE (e.g. left over from a
        // fill aborted by reset) are deliberately dropped.
        issue_nxt = '0;
        recv_nxt  = '0;
        if (d_wr_req) begin
          state_nxt = WRITE;
        end else if (grant_d) begin
          state_nxt = FILL_D;
          blk_nxt   = d_miss_addr & ~OFF_MASK;
        end else if (i_miss) begin
          state_nxt = FILL_I;
          blk_nxt   = i_miss_addr & ~OFF_MASK;
        end
      end

      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_wr_addr;
        mem_wdata = d_wr_data;
        wr_done   = 1'b1;
        state_nxt = IDLE;
      end

      FILL_I, FILL_D: begin
        // Issue side: one read per cycle until the whole block is requested.
        // Address arithmetic wraps at 16 bits by construction.
        if (issue_cnt < CNT_FULL) begin
          mem_en    = 1'b1;
          mem_addr  = blk_addr + (16'(issue_cnt) << 1);
          issue_nxt = issue_cnt + CNT_ONE;
        end

        // Receive side: issue and receive run independently, so overlap of
        // late issues with early returns is handled naturally.
        if (mem_data_valid) begin
          fill_addr = blk_addr + (16'(recv_cnt) << 1);
          fill_data = mem_rdata;
          i_fill_we = !fill_is_d;
          d_fill_we = fill_is_d;
          recv_nxt  = recv_cnt + CNT_ONE;
          if (recv_cnt == CNT_LAST) begin
            i_tag_we  = !fill_is_d;
            d_tag_we  = fill_is_d;
            state_nxt = IDLE;
            issue_nxt = '0;
            recv_nxt  = '0;
`ifdef ARB_RR_EN
            last_fill_nxt = fill_is_d;
`endif
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= IDLE;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      blk_addr  <= '0;
`ifdef ARB_RR_EN
      last_fill <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      issue_cnt <= issue_nxt;
      recv_cnt  <= recv_nxt;
      blk_addr  <= blk_nxt;
`ifdef ARB_RR_EN
      last_fill <= last_fill_nxt;
`endif
    end
  end

endmodule
